// File: rtl/logic_gate_pkg.sv
// Shared opcode definitions and the bitwise gate evaluation used by the
// logic-gate datapath.
package logic_gate_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } gate_op_t;

    // Evaluated at the maximum width; callers truncate to their own WIDTH.
    function automatic logic [MAX_WIDTH-1:0] gate_eval(
        input gate_op_t              op,
        input logic [MAX_WIDTH-1:0]  a,
        input logic [MAX_WIDTH-1:0]  b
    );
        logic [MAX_WIDTH-1:0] y;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/logic_gate_unit.sv
// Purely combinational gate datapath: evaluates one opcode on a WIDTH-bit
// operand pair and flags the reserved opcode.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    assign y   = WIDTH'(gate_eval(gate_op_t'(op), MAX_WIDTH'(a), MAX_WIDTH'(b)));
    assign err = (gate_op_t'(op) == OP_RSVD);

endmodule

// File: rtl/logic_gate_arbiter.sv
// Two-requester round-robin front end for a shared logic-gate unit, with a
// single registered response slot and per-requester completion counters.
module logic_gate_arbiter
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [5:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_y,
    output logic               rsp_err,
    output logic [CNT_W-1:0]   done_cnt0,
    output logic [CNT_W-1:0]   done_cnt1
);

    logic             ptr;
    logic             win;
    logic             slot_free;
    logic             accept;
    logic             consume;
    gate_op_t         sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] unit_y;
    logic             unit_err;

    // A lone requester always wins; on contention the pointer decides.
    assign win       = (req_valid == 2'b11) ? ptr : req_valid[1];
    assign slot_free = !rsp_valid || rsp_ready;
    assign accept    = (|req_valid) && slot_free && !rst;
    assign consume   = rsp_valid && rsp_ready;

    assign req_ready[0] = accept && !win;
    assign req_ready[1] = accept && win;

    assign sel_op = gate_op_t'(win ? req_op[5:3] : req_op[2:0]);
    assign sel_a  = win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign sel_b  = win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

    logic_gate_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (unit_y),
        .err (unit_err)
    );

    // Consume and accept may coincide; the slot then reloads and stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            ptr       <= 1'b0;
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else begin
            if (consume) begin
                if (rsp_id)
                    done_cnt1 <= done_cnt1 + 1'b1;
                else
                    done_cnt0 <= done_cnt0 + 1'b1;
            end
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_y     <= unit_y;
                rsp_id    <= win;
                rsp_err   <= unit_err;
                ptr       <= !win;
            end else if (consume) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
